demux_deser_4ch: RTL and testbench
==================================

Name: demux_deser_4ch

Overview:
- Downstream consumer of the 1:4 bit demux.
- The upstream controller drives the demux `sel` and pulses `bit_valid` once per routed bit. This block shifts each channel's bits into a WIDTH-bit word and holds one completed word per channel.
- A round-robin arbiter merges the four channels into a single valid/ready output stream tagged with the channel id.

Parameters:
- WIDTH, 8, bits per assembled word (range 2..32); serial order is MSB first.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- bit_valid  input  1  one routed bit is present on the selected y line this cycle
- sel  input  2  demux select, same value that drives the demux; 0→y1, 1→y2, 2→y3, 3→y4
- y1  input  1  demux output channel 0
- y2  input  1  demux output channel 1
- y3  input  1  demux output channel 2
- y4  input  1  demux output channel 3
- out_ready  input  1  downstream accepts the output word
- clr_ovf  input  1  synchronous clear of all overrun flags
- out_valid  output  1  out_data/out_ch hold a word
- out_data  output  WIDTH  assembled word
- out_ch  output  2  source channel of out_data
- ovf  output  4  sticky per-channel overrun flags

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all shift registers, bit counters, hold registers and hold_full flags clear to 0.
  - out_valid=0, out_data=0, out_ch=0, ovf=4'b0.
  - round-robin pointer set so channel 0 has first priority (last_grant=3).
  - Reset mid-word discards partial words and any held or output words.
- Bit capture, at each edge with bit_valid=1:
  - c=sel; bit b = y(c+1).
  - shift_c <= {shift_c[WIDTH-2:0], b}; cnt_c <= cnt_c+1.
  - y lines of non-selected channels are ignored.
  - bit_valid=0 changes nothing in the lanes.
- Word completion (cnt_c==WIDTH-1 with bit_valid and sel==c):
  - cnt_c <= 0.
  - If hold_c is free, or is being granted to the output on this same edge: hold_c <= {shift_c[WIDTH-2:0], b} and hold_full_c <= 1.
  - Otherwise the word is dropped and ovf[c] <= 1. The lane keeps running; the next bit starts a fresh word.
- Overrun flags:
  - ovf bits are sticky.
  - clr_ovf=1 clears all bits; if set and clear coincide for a channel, set wins.
- Output register:
  - free when out_valid=0 or (out_valid & out_ready) at the edge.
  - When free and any hold_full: grant the first full channel searching from last_grant+1 mod 4 upward.
  - Load out_data/out_ch from the granted hold, clear that hold_full, update last_grant, out_valid <= 1.
  - If free and no hold_full: out_valid <= 0.
- Handshake:
  - out_data/out_ch stay stable while out_valid=1 and out_ready=0.
  - A transfer occurs on an edge with out_valid & out_ready.
  - Back-to-back transfers are allowed: one word per cycle sustained.
- Latency: final bit sampled at edge N → hold_full at N → out_valid high after edge N+1, provided the output register is free at N+1.
- Simultaneous events:
  - All four channels can complete on different cycles while out_ready=0. Holds fill, the output shows the first granted word, and the rest drain in round-robin order after out_ready rises.
  - Same-edge grant of hold_c plus completion on channel c: the new word enters hold_c with no ovf.
- Width: cnt_c is clog2(WIDTH) bits and wraps to 0 only at completion.

Decomposition:
- Shared package/header holds:
  - NUM_CH=4 constant
  - channel-id width (2)
  - default WIDTH
- One sub-module, demux_deser_lane: shift register, counter, hold register, hold_full, ovf set logic for one channel.
  - Inputs: clk, rst_n, bit_en (bit_valid & sel==c), bit, grant, clr_ovf.
  - Outputs: hold, hold_full, ovf.
  - Instantiated 4×; the top contains the round-robin arbiter and output register.

Test Plan:
- Reset then ch2 only: sel=2, y3 bits 1,0,1,0,0,1,0,1 over 8 bit_valid cycles with out_ready=1 → out_valid one cycle after the hold fills, out_data=8'hA5, out_ch=2, ovf=0.
- Interleave ch0 and ch3 bit-by-bit with 2-cycle bit_valid gaps: ch0 word 8'h3C, ch3 word 8'hC3 → two output words in completion order, correct data, gaps cause no corruption.
- out_ready=0; complete words on ch3, ch1, ch0, ch2 (values 8'h03, 8'h01, 8'h00, 8'h02); then out_ready=1 → first output is ch3 (first to fill). The others drain in the order ch0, ch1, ch2, one per cycle, with stable data while stalled.
- Overrun: out_ready=0; send two full words to ch1 while a prior ch0 word occupies the output → first ch1 word held, second dropped, ovf=4'b0010. clr_ovf pulse → ovf=0. A coincident set on the same edge leaves the bit at 1.
- Reset mid-operation: 5 bits into ch1 with hold_full on ch0 and out_valid=1; assert rst_n=0 asynchronously → outputs 0 immediately. After release, 8 fresh ch1 bits 8'hFF → out_data=8'hFF with no stale bits.
- Same-edge grant and refill: ch0 hold full and being granted on the edge where ch0's next word completes → both words emerge in order, ovf[0]=0.

Source files
------------

// File: rtl/demux_deser_4ch_pkg.sv
// Shared constants for the 4-channel demux deserializer.
package demux_deser_4ch_pkg;
  localparam int NUM_CH    = 4;
  localparam int CH_W      = 2;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/demux_deser_lane.sv
// One channel: MSB-first shift register, bit counter, single-word hold
// buffer and sticky overrun flag.
module demux_deser_lane
  import demux_deser_4ch_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_en,
  input  logic             bit_i,
  input  logic             grant,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] hold,
  output logic             hold_full,
  output logic             ovf
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shift_q, shift_d, hold_q, hold_d, word;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hold_full_q, hold_full_d, ovf_q, ovf_d, done;

  // Shift/count, capture completed word into hold (a same-edge grant frees it), flag overruns.
  always_comb begin
    word        = {shift_q[WIDTH-2:0], bit_i};
    done        = bit_en && (cnt_q == LAST);
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q & ~grant;
    ovf_d       = ovf_q & ~clr_ovf;
    if (bit_en) begin
      shift_d = word;
      cnt_d   = done ? '0 : cnt_q + CNT_W'(1);
    end
    if (done) begin
      if (!hold_full_q || grant) begin
        hold_d      = word;
        hold_full_d = 1'b1;
      end else begin
        ovf_d = 1'b1;  // set wins over a coincident clear
      end
    end
  end

  // Lane state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ovf_q       <= ovf_d;
    end
  end

  assign hold      = hold_q;
  assign hold_full = hold_full_q;
  assign ovf       = ovf_q;
endmodule

// File: rtl/demux_deser_4ch.sv
// Four deserializer lanes merged into one valid/ready stream by a
// round-robin arbiter feeding a single output register.
module demux_deser_4ch
  import demux_deser_4ch_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_valid,
  input  logic [1:0]       sel,
  input  logic             y1,
  input  logic             y2,
  input  logic             y3,
  input  logic             y4,
  input  logic             out_ready,
  input  logic             clr_ovf,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_ch,
  output logic [3:0]       ovf
);
  logic [NUM_CH-1:0][WIDTH-1:0] hold;
  logic [NUM_CH-1:0]            hold_full, grant, ovf_v, y_v;

  logic             out_valid_q, out_valid_d, out_free, found;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]  out_ch_q, out_ch_d, last_q, last_d, gidx, idx;

  assign y_v = {y4, y3, y2, y1};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    demux_deser_lane #(.WIDTH(WIDTH)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .bit_en    (bit_valid && (sel == CH_W'(c))),
      .bit_i     (y_v[c]),
      .grant     (grant[c]),
      .clr_ovf   (clr_ovf),
      .hold      (hold[c]),
      .hold_full (hold_full[c]),
      .ovf       (ovf_v[c])
    );
  end

  // Round-robin pick starting after last grant; load output register when it frees up.
  always_comb begin
    out_free    = !out_valid_q || out_ready;
    found       = 1'b0;
    gidx        = last_q;
    idx         = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = last_q + CH_W'(i);
      if (!found && hold_full[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
    grant       = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    last_d      = last_q;
    if (out_free) begin
      if (found) begin
        grant[gidx] = 1'b1;
        out_valid_d = 1'b1;
        out_data_d  = hold[gidx];
        out_ch_d    = gidx;
        last_d      = gidx;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Output register and arbiter pointer; channel 0 has first priority after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      last_q      <= CH_W'(NUM_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign ovf       = ovf_v;
endmodule

// File: tb/tb_demux_deser_4ch.sv
// Directed bench with a behavioural reference model and a per-cycle compare.
module tb_demux_deser_4ch;
  localparam int W = 8;

  logic         clk, rst_n, bit_valid, y1, y2, y3, y4, out_ready, clr_ovf;
  logic [1:0]   sel;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_ch;
  logic [3:0]   ovf;

  int errors = 0;
  int checks = 0;

  demux_deser_4ch #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .sel(sel),
    .y1(y1), .y2(y2), .y3(y3), .y4(y4), .out_ready(out_ready),
    .clr_ovf(clr_ovf), .out_valid(out_valid), .out_data(out_data),
    .out_ch(out_ch), .ovf(ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-channel bit count and running word, one-slot hold, output slot.
  int         m_cnt [4];
  logic [W-1:0] m_sh [4];
  logic [W-1:0] m_hold [4];
  bit         m_hf [4];
  logic [3:0] m_ovf;
  bit         m_ov;
  logic [W-1:0] m_od;
  int         m_och, m_last;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        m_cnt[k] = 0; m_sh[k] = '0; m_hold[k] = '0; m_hf[k] = 0;
      end
      m_ovf = '0; m_ov = 0; m_od = '0; m_och = 0; m_last = 3;
    end else begin
      int g, c;
      bit free;
      logic [3:0] lines, novf;
      free  = !m_ov || out_ready;
      novf  = clr_ovf ? 4'b0 : m_ovf;
      g     = -1;
      if (free)
        for (int k = 1; k <= 4; k++)
          if (g < 0 && m_hf[(m_last + k) % 4]) g = (m_last + k) % 4;
      if (g >= 0) begin
        m_od = m_hold[g]; m_och = g; m_ov = 1; m_hf[g] = 0; m_last = g;
      end else if (free) m_ov = 0;
      if (bit_valid) begin
        lines = {y4, y3, y2, y1};
        c = int'(sel);
        m_sh[c] = (m_sh[c] << 1) | W'(lines[c]);
        m_cnt[c]++;
        if (m_cnt[c] == W) begin
          m_cnt[c] = 0;
          if (!m_hf[c]) begin m_hold[c] = m_sh[c]; m_hf[c] = 1; end
          else novf[c] = 1'b1;
        end
      end
      m_ovf = novf;
    end
  end

  // Compare DUT against model mid-cycle, and log every accepted transfer.
  logic [1:0]   log_ch [$];
  logic [W-1:0] log_d  [$];

  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        chk("out_data", 32'(out_data), 32'(m_od));
        chk("out_ch", 32'(out_ch), 32'(m_och));
      end
      chk("ovf", 32'(ovf), 32'(m_ovf));
      if (out_valid && out_ready) begin
        log_ch.push_back(out_ch);
        log_d.push_back(out_data);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_bit(input logic [1:0] c, input logic b);
    logic [3:0] ys;
    ys = 4'($urandom);
    ys[c] = b;
    {y4, y3, y2, y1} = ys;
    sel = c;
    bit_valid = 1'b1;
    step();
    bit_valid = 1'b0;
  endtask

  task automatic send_word(input logic [1:0] c, input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) send_bit(c, w[i]);
  endtask

  task automatic wait_log(input int n);
    int k;
    k = 0;
    while (log_d.size() < n && k < 40) begin step(); k++; end
    chk("log_wait", 32'(log_d.size() >= n), 32'd1);
  endtask

  task automatic clear_log();
    log_ch.delete();
    log_d.delete();
  endtask

  task automatic check_log(input int i, input logic [1:0] ch, input logic [W-1:0] d);
    if (i < log_d.size()) begin
      chk($sformatf("log%0d_ch", i), 32'(log_ch[i]), 32'(ch));
      chk($sformatf("log%0d_data", i), 32'(log_d[i]), 32'(d));
    end else chk($sformatf("log%0d_present", i), 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] w;
    rst_n = 1'b0; bit_valid = 1'b0; sel = 2'd0;
    {y4, y3, y2, y1} = 4'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    step();

    // Single channel 2 word with latency check.
    out_ready = 1'b1;
    clear_log();
    send_word(2'd2, 8'hA5);
    chk("t1_lat_valid0", 32'(out_valid), 32'd0);
    step();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'hA5);
    chk("t1_ch", 32'(out_ch), 32'd2);
    chk("t1_ovf", 32'(ovf), 32'd0);
    idle(3);
    check_log(0, 2'd2, 8'hA5);

    // Interleaved ch0/ch3 with gaps.
    clear_log();
    for (int i = W - 1; i >= 0; i--) begin
      w = 8'h3C; send_bit(2'd0, w[i]); idle(2);
      w = 8'hC3; send_bit(2'd3, w[i]); idle(2);
    end
    wait_log(2);
    check_log(0, 2'd0, 8'h3C);
    check_log(1, 2'd3, 8'hC3);

    // Stalled fill of all channels then round-robin drain.
    idle(2);
    clear_log();
    out_ready = 1'b0;
    send_word(2'd3, 8'h03);
    send_word(2'd1, 8'h01);
    send_word(2'd0, 8'h00);
    send_word(2'd2, 8'h02);
    idle(2);
    chk("t3_stall_data", 32'(out_data), 32'h03);
    chk("t3_stall_ch", 32'(out_ch), 32'd3);
    out_ready = 1'b1;
    wait_log(4);
    check_log(0, 2'd3, 8'h03);
    check_log(1, 2'd0, 8'h00);
    check_log(2, 2'd1, 8'h01);
    check_log(3, 2'd2, 8'h02);

    // Overrun, clear, coincident set/clear.
    idle(2);
    clear_log();
    out_ready = 1'b0;
    send_word(2'd0, 8'h11);
    send_word(2'd1, 8'h22);
    send_word(2'd1, 8'h33);
    chk("t4_ovf_set", 32'(ovf), 32'b0010);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    chk("t4_ovf_clr", 32'(ovf), 32'd0);
    w = 8'h44;
    for (int i = W - 1; i >= 1; i--) send_bit(2'd1, w[i]);
    clr_ovf = 1'b1;
    send_bit(2'd1, w[0]);
    clr_ovf = 1'b0;
    chk("t4_ovf_coincide", 32'(ovf), 32'b0010);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    out_ready = 1'b1;
    wait_log(2);
    check_log(0, 2'd0, 8'h11);
    check_log(1, 2'd1, 8'h22);
    idle(3);
    chk("t4_drained", 32'(log_d.size()), 32'd2);

    // Asynchronous reset mid-operation.
    out_ready = 1'b0;
    send_word(2'd0, 8'hAA);
    send_word(2'd0, 8'hBB);
    for (int i = 0; i < 5; i++) send_bit(2'd1, 1'(i % 2 == 0));
    chk("t5_pre_valid", 32'(out_valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_data", 32'(out_data), 32'd0);
    chk("t5_rst_ch", 32'(out_ch), 32'd0);
    chk("t5_rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    step();
    clear_log();
    out_ready = 1'b1;
    send_word(2'd1, 8'hFF);
    wait_log(1);
    check_log(0, 2'd1, 8'hFF);
    idle(4);
    chk("t5_only_one", 32'(log_d.size()), 32'd1);

    // Same-edge grant and refill on ch0.
    clear_log();
    out_ready = 1'b0;
    send_word(2'd1, 8'h5A);
    send_word(2'd0, 8'hC6);
    w = 8'h39;
    for (int i = W - 1; i >= 1; i--) send_bit(2'd0, w[i]);
    out_ready = 1'b1;
    send_bit(2'd0, w[0]);
    wait_log(3);
    check_log(0, 2'd1, 8'h5A);
    check_log(1, 2'd0, 8'hC6);
    check_log(2, 2'd0, 8'h39);
    chk("t6_ovf", 32'(ovf), 32'd0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
